// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - fetch/data requester and shared-memory signals of the arbiter
interface mips_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port I/D memory arbiter, data priority with fetch starvation guard
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  mips_mem_arbiter_if.slave bus,
  output logic [1:0]       owner,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_IF    = 2'b01;
  localparam logic [1:0] OWN_D     = 2'b10;
  localparam int         WAIT_LAST = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [3:0] SMAX      = 4'(STARVE_MAX);

  state_t        state, state_nxt;
  logic [2:0]    wait_cnt;
  logic [3:0]    starve_cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          if_elig, d_elig;
  logic          grant_if, grant_d;

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    // A requester whose ack is showing this cycle is finishing, not asking again.
    if_elig   = bus.if_req && !bus.if_ack;
    d_elig    = bus.d_req && !bus.d_ack;
    case (state)
      IDLE: begin
        if (d_elig && (!if_elig || starve_cnt != SMAX)) begin
          grant_d   = 1'b1;
          state_nxt = ISSUE;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:    if (wait_cnt == 3'(WAIT_LAST)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      starve_cnt   <= 4'd0;
      owner        <= OWN_NONE;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      bus.mem_en <= grant_if || grant_d;
      bus.mem_we <= grant_d && bus.d_we;
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      wait_cnt   <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;

      if (grant_d) begin
        owner     <= OWN_D;
        lat_we    <= bus.d_we;
        lat_addr  <= bus.d_addr;
        lat_wdata <= bus.d_wdata;
        if (!bus.if_req)
          starve_cnt <= 4'd0;
        else if (starve_cnt != SMAX)
          starve_cnt <= starve_cnt + 4'd1;
      end else if (grant_if) begin
        owner      <= OWN_IF;
        lat_we     <= 1'b0;
        lat_addr   <= bus.if_addr;
        starve_cnt <= 4'd0;
      end

      // Response capture; the ack surfaces in the following IDLE cycle together with owner=none.
      if (state == RESP) begin
        owner <= OWN_NONE;
        if (owner == OWN_IF) begin
          bus.if_ack   <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end else begin
          bus.d_ack <= 1'b1;
          if (!lat_we) bus.d_rdata <= bus.mem_rdata;
        end
      end
    end
  end
endmodule
